// File: rtl/sp_ram_ctl.sv
// rtl/sp_ram_ctl.sv - single-port block-RAM controller with byte lanes, timed read strobe
// and a clear sequencer that fills the array with INIT_VAL after reset or on init.
module sp_ram_ctl #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 12,
   parameter int                LANES    = DATA_W / 8,
   parameter int                OUT_REG  = 1,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              init,
   output logic              busy,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [LANES-1:0]  req_be,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata
);

   localparam int                DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   typedef enum logic [1:0] {CLEAR, RUN, DRAIN} state_t;

   state_t            state;
   logic [ADDR_W-1:0] clr_addr;
   logic              busy_q;
   logic              run_q;

   logic              accept;
   logic              rd_acc;
   logic              clr_wr;
   logic              mem_ce;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [LANES-1:0]  mem_be;
   logic [DATA_W-1:0] mem_wdata;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] ram_q;
   logic              rd_v0;
   logic              rd_v1;
   logic [DATA_W-1:0] oreg_q;
   logic              out_v;
   logic              pipe_busy;

   // init removes ready in the same cycle so a coincident request is never taken
   assign req_ready = run_q & ~init;
   assign busy      = busy_q;
   assign accept    = req_valid & req_ready;
   assign rd_acc    = accept & ~req_we;
   assign clr_wr    = (state == CLEAR);

   assign mem_ce    = clr_wr | accept;
   assign mem_we    = clr_wr | (accept & req_we);
   assign mem_addr  = clr_wr ? clr_addr : req_addr;
   assign mem_be    = clr_wr ? {LANES{1'b1}} : req_be;
   assign mem_wdata = clr_wr ? INIT_VAL : req_wdata;

   always_ff @(posedge clk) begin
      if (mem_ce) begin
         if (mem_we) begin
            for (int i = 0; i < LANES; i++) begin
               if (mem_be[i]) begin
                  mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
               end
            end
         end else begin
            ram_q <= mem[mem_addr];
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic mem_oce;
         assign mem_oce = rd_v0;
         assign out_v   = rd_v1;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               rd_v1  <= 1'b0;
               oreg_q <= '0;
            end else begin
               rd_v1 <= mem_oce;
               if (mem_oce) begin
                  oreg_q <= ram_q;
               end
            end
         end
      end else begin : g_noreg
         assign rd_v1  = 1'b0;
         assign oreg_q = ram_q;
         assign out_v  = rd_v0;
      end
   endgenerate

   assign pipe_busy = rd_v0 | rd_v1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= CLEAR;
         clr_addr  <= '0;
         busy_q    <= 1'b1;
         run_q     <= 1'b0;
         rd_v0     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rd_v0     <= rd_acc;
         rsp_valid <= out_v;
         if (out_v) begin
            rsp_rdata <= oreg_q;
         end

         case (state)
            CLEAR: begin
               clr_addr <= clr_addr + 1'b1;
               if (clr_addr == LAST_ADDR) begin
                  state  <= RUN;
                  busy_q <= 1'b0;
                  run_q  <= 1'b1;
               end
            end
            RUN: begin
               if (init) begin
                  run_q    <= 1'b0;
                  busy_q   <= 1'b1;
                  clr_addr <= '0;
                  state    <= pipe_busy ? DRAIN : CLEAR;
               end
            end
            DRAIN: begin
               // in-flight reads finish before the array is overwritten
               if (!pipe_busy) begin
                  state <= CLEAR;
               end
            end
            default: begin
               state <= CLEAR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sp_ram_ctl.sv
// tb/tb_sp_ram_ctl.sv - scoreboard bench for sp_ram_ctl, OUT_REG=0 and OUT_REG=1 driven in lockstep
module tb_sp_ram_ctl;

   localparam logic [15:0] INIT_VAL = 16'hA5A5;

   typedef struct {
      logic [15:0] data;
      int          edge_n;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             init = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_we = 1'b0;
   logic [1:0]       req_be = '0;
   logic [3:0]       req_addr = '0;
   logic [15:0]      req_wdata = '0;
   logic [1:0]       busy;
   logic [1:0]       req_ready;
   logic [1:0]       rsp_valid;
   logic [1:0][15:0] rsp_rdata;

   int          cyc = 0;
   int          n_vec = 0;
   int          n_err = 0;
   exp_t        exp_list[$];
   int          rp[2] = '{0, 0};
   int          lat[2] = '{1, 2};
   logic [15:0] last_exp[2] = '{16'h0, 16'h0};
   logic [15:0] ref_mem[16];

   sp_ram_ctl #(.DATA_W(16), .ADDR_W(4), .OUT_REG(0), .INIT_VAL(INIT_VAL)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .init(init), .busy(busy[0]),
      .req_valid(req_valid), .req_ready(req_ready[0]), .req_we(req_we), .req_be(req_be),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0])
   );

   sp_ram_ctl #(.DATA_W(16), .ADDR_W(4), .OUT_REG(1), .INIT_VAL(INIT_VAL)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .init(init), .busy(busy[1]),
      .req_valid(req_valid), .req_ready(req_ready[1]), .req_we(req_we), .req_be(req_be),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1])
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // response monitor: strobes are matched in order against the scoreboard
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!reset_n) begin
            rp[d]       = exp_list.size();
            last_exp[d] = 16'h0;
         end else if (rsp_valid[d]) begin
            if (rp[d] < exp_list.size()) begin
               check_eq($sformatf("rdata%0d", d), rsp_rdata[d], exp_list[rp[d]].data);
               check_eq($sformatf("latency%0d", d), cyc, exp_list[rp[d]].edge_n + lat[d]);
               last_exp[d] = exp_list[rp[d]].data;
               rp[d]++;
            end else begin
               check_eq($sformatf("unexpected_rsp%0d", d), rsp_valid[d], 1'b0);
            end
         end else begin
            check_eq($sformatf("rdata_hold%0d", d), rsp_rdata[d], last_exp[d]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int a = 0; a < 16; a++) ref_mem[a] = INIT_VAL;
   endtask

   task automatic do_read(input int addr);
      exp_t e;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = addr[3:0];
      e.data    = ref_mem[addr];
      e.edge_n  = cyc + 1;
      exp_list.push_back(e);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic do_write(input int addr, input logic [15:0] data, input logic [1:0] be);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = addr[3:0];
      req_wdata = data;
      req_be    = be;
      if (be[0]) ref_mem[addr][7:0]  = data[7:0];
      if (be[1]) ref_mem[addr][15:8] = data[15:8];
      tick();
      req_valid = 1'b0;
      req_we    = 1'b0;
   endtask

   task automatic wait_idle(input int exp0, input int exp1, input string tag);
      int n0 = 0;
      int n1 = 0;
      int t  = 0;
      do begin
         @(negedge clk);
         if (busy[0]) n0++;
         if (busy[1]) n1++;
         t++;
      end while (busy != 2'b00 && t < 200);
      check_eq({tag, "_busy0"}, n0, exp0);
      check_eq({tag, "_busy1"}, n1, exp1);
      check_eq({tag, "_ready"}, req_ready, 2'b11);
      tick();
   endtask

   initial begin
      int n0;
      int n1;

      @(negedge clk);
      check_eq("rst_busy", busy, 2'b11);
      check_eq("rst_ready", req_ready, 2'b00);
      check_eq("rst_rsp_valid", rsp_valid, 2'b00);
      check_eq("rst_rdata0", rsp_rdata[0], 16'h0);
      check_eq("rst_rdata1", rsp_rdata[1], 16'h0);
      tick();
      tick();
      reset_n = 1'b1;
      clear_model();
      wait_idle(16, 16, "rst_release");

      for (int a = 0; a < 16; a++) do_read(a);
      repeat (4) tick();

      do_write(3, 16'h1234, 2'b11);
      do_write(3, 16'hFFEE, 2'b01);
      do_write(3, 16'hBEEF, 2'b00);
      do_read(3);
      repeat (4) tick();

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(1, 0) == 1)
            do_write($urandom_range(15, 0), 16'($urandom), 2'($urandom));
         else
            do_read($urandom_range(15, 0));
      end
      repeat (4) tick();

      // init right behind two reads, with a read presented in the init cycle
      do_write(5, 16'h5555, 2'b11);
      do_write(6, 16'h6666, 2'b11);
      do_read(5);
      do_read(6);
      init      = 1'b1;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 4'd7;
      @(negedge clk);
      check_eq("ready_in_init", req_ready, 2'b00);
      tick();
      init      = 1'b0;
      req_valid = 1'b0;
      clear_model();
      wait_idle(17, 18, "drain");
      do_read(5);
      do_read(6);
      repeat (4) tick();

      // init during CLEAR must not extend or restart the pass
      do_write(2, 16'h2222, 2'b11);
      init = 1'b1;
      tick();
      init = 1'b0;
      clear_model();
      n0 = 0;
      n1 = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy[0]) n0++;
         if (busy[1]) n1++;
         init = (i == 5);
      end
      check_eq("init_in_clear_busy0", n0, 16);
      check_eq("init_in_clear_busy1", n1, 16);
      check_eq("init_in_clear_ready", req_ready, 2'b11);
      tick();
      do_read(2);
      repeat (4) tick();

      // reset with a read in flight: its response is discarded
      do_read(4);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      clear_model();
      wait_idle(16, 16, "rst_mid_read");

      // reset mid-clear at address 9 with a read request waiting
      do_write(14, 16'h1111, 2'b11);
      do_write(9, 16'h9999, 2'b11);
      init = 1'b1;
      tick();
      init = 1'b0;
      repeat (9) tick();
      reset_n   = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 4'd2;
      tick();
      reset_n   = 1'b1;
      req_valid = 1'b0;
      clear_model();
      wait_idle(16, 16, "rst_mid_clear");
      do_read(14);
      do_read(9);
      do_read(0);
      repeat (6) tick();

      check_eq("all_rsp0", rp[0], exp_list.size());
      check_eq("all_rsp1", rp[1], exp_list.size());

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
